// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the mux scan sequencer.
package mux_scan_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam logic [SEL_W-1:0] LAST_CH = 2'd3;
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Control, mux and sample/frame signals of the scan sequencer.
// There is no valid/ready back-pressure: sample_valid and frame_valid are single-cycle
// pulses that the consumer must capture on the edge where they are high.
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic              start;
  logic              cont;
  logic              stop_req;
  logic              mux_out;
  logic [SEL_W-1:0]  sel;
  logic              busy;
  logic              sample_valid;
  logic [SEL_W-1:0]  sample_ch;
  logic              sample_bit;
  logic [NUM_CH-1:0] frame;
  logic              frame_valid;

  modport slave (
    input  start, cont, stop_req, mux_out,
    output sel, busy, sample_valid, sample_ch, sample_bit, frame, frame_valid
  );

  modport master (
    output start, cont, stop_req, mux_out,
    input  sel, busy, sample_valid, sample_ch, sample_bit, frame, frame_valid
  );
endinterface

// File: rtl/mux_scan_ctrl_dwell_cnt.sv
// Dwell counter: counts while enabled and wraps to 0 after DWELL cycles.
// terminal is high during the last cycle of each dwell.
module scan_dwell_cnt #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count;

  assign terminal = (count == TERM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (terminal) count <= '0;
      else          count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a 4-to-1 mux: holds each select for DWELL cycles, samples the mux output
// at the end of each dwell and publishes a 4-bit frame after channel 3.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_scan_ctrl_if.slave  bus,
  output state_t          state_dbg
);
  state_t            state, state_nx;
  logic [SEL_W-1:0]  sel_q, sel_nx;
  logic              busy_q, busy_nx;
  logic              sv_q, sv_nx;
  logic [SEL_W-1:0]  sch_q, sch_nx;
  logic              sbit_q, sbit_nx;
  logic [NUM_CH-1:0] frame_q, frame_nx;
  logic              fv_q, fv_nx;
  logic [NUM_CH-1:0] work_q, work_nx;
  logic [NUM_CH-1:0] work_wr;
  logic              cnt_clear;
  logic              terminal;

  scan_dwell_cnt #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .enable   (state == SCAN),
    .terminal (terminal)
  );

  always_comb begin
    state_nx  = state;
    sel_nx    = sel_q;
    busy_nx   = busy_q;
    sv_nx     = 1'b0;
    sch_nx    = sch_q;
    sbit_nx   = sbit_q;
    frame_nx  = frame_q;
    fv_nx     = 1'b0;
    work_nx   = work_q;
    cnt_clear = 1'b0;
    work_wr   = work_q;
    work_wr[sel_q] = bus.mux_out;

    case (state)
      IDLE: begin
        cnt_clear = 1'b1;
        if (bus.start && !bus.stop_req) begin
          state_nx = SCAN;
          sel_nx   = '0;
          busy_nx  = 1'b1;
          work_nx  = '0;
        end
      end
      SCAN: begin
        // Abort beats a coincident sample edge: nothing is sampled or published.
        if (bus.stop_req) begin
          state_nx  = IDLE;
          busy_nx   = 1'b0;
          sel_nx    = '0;
          cnt_clear = 1'b1;
        end else if (terminal) begin
          work_nx = work_wr;
          sv_nx   = 1'b1;
          sch_nx  = sel_q;
          sbit_nx = bus.mux_out;
          if (sel_q != LAST_CH) begin
            sel_nx = sel_q + 2'd1;
          end else begin
            frame_nx = work_wr;
            fv_nx    = 1'b1;
            sel_nx   = '0;
            if (bus.cont) begin
              work_nx = '0;
            end else begin
              state_nx = IDLE;
              busy_nx  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
        sel_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      sv_q    <= 1'b0;
      sch_q   <= '0;
      sbit_q  <= 1'b0;
      frame_q <= '0;
      fv_q    <= 1'b0;
      work_q  <= '0;
    end else begin
      state   <= state_nx;
      sel_q   <= sel_nx;
      busy_q  <= busy_nx;
      sv_q    <= sv_nx;
      sch_q   <= sch_nx;
      sbit_q  <= sbit_nx;
      frame_q <= frame_nx;
      fv_q    <= fv_nx;
      work_q  <= work_nx;
    end
  end

  assign bus.sel          = sel_q;
  assign bus.busy         = busy_q;
  assign bus.sample_valid = sv_q;
  assign bus.sample_ch    = sch_q;
  assign bus.sample_bit   = sbit_q;
  assign bus.frame        = frame_q;
  assign bus.frame_valid  = fv_q;
  assign state_dbg        = state;
endmodule
